// File: rtl/cpu_pkg.sv
// Shared types for the data-memory responder: word width, FSM state encoding
// and the posted-write buffer entry layout.
package cpu_pkg;

    localparam int DSIZE = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic [DSIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: circular FIFO of {addr, data} entries with a parallel
// address lookup that returns the newest matching entry for load forwarding.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int DSIZE = cpu_pkg::DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_addr,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             single,
    output logic [DSIZE-1:0] head_addr,
    output logic [DSIZE-1:0] head_data,
    input  logic [DSIZE-1:0] lookup_addr,
    output logic             hit,
    output logic [DSIZE-1:0] hit_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [DEPTH-1:0] valid;
    logic [DSIZE-1:0] addr_mem [DEPTH];
    logic [DSIZE-1:0] data_mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;
    logic [AW-1:0]    slot;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign used   = wr_ptr - rd_ptr;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr == rd_ptr);
    assign single = (used == PTR_INC);

    // A push into a full buffer is legal only when the head leaves on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign head_addr = addr_mem[rd_idx];
    assign head_data = data_mem[rd_idx];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
        end else begin
            if (pop_ok) begin
                valid[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_INC;
            end
            if (push_ok) begin
                valid[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_INC;
            end
        end
    end

    // NOTE: entry storage is not reset; the valid bits alone decide whether a slot counts.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= push_data;
        end
    end

    // Scan oldest to newest so the last match, i.e. the newest store, wins.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_idx + AW'(i);
            if (valid[slot] && (addr_mem[slot] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[slot];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posts stores into a write buffer, forwards loads that
// hit it, and serialises buffered writes and load misses onto the backing memory.
module dmem_responder #(
    parameter int DEPTH = 4,
    parameter int DSIZE = cpu_pkg::DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] cpu_addr,
    input  logic [DSIZE-1:0] cpu_wdata,
    input  logic             cpu_wen,
    input  logic             cpu_ren,
    output logic [DSIZE-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [DSIZE-1:0] mem_rdata
);

    cpu_pkg::state_t state;
    cpu_pkg::state_t state_nxt;
    cpu_pkg::state_t next_busy;

    logic             load_req;
    logic             wr_ack;
    logic             rd_ack;
    logic             miss;
    logic             miss_pending;
    logic             stall_raw;
    logic             push;
    logic             nonempty_nxt;
    logic             rd_done;
    logic [DSIZE-1:0] rd_addr_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_single;
    logic [DSIZE-1:0] head_addr;
    logic [DSIZE-1:0] head_data;
    logic             hit;
    logic [DSIZE-1:0] hit_data;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .DSIZE (DSIZE)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (cpu_addr),
        .push_data   (cpu_wdata),
        .pop         (wr_ack),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .single      (fifo_single),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .lookup_addr (cpu_addr),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // A simultaneous store and load is a store; the load is dropped.
    assign load_req = cpu_ren & ~cpu_wen;
    assign wr_ack   = (state == cpu_pkg::WR_BUSY) & mem_ack;
    assign rd_ack   = (state == cpu_pkg::RD_BUSY) & mem_ack;

    // rd_done marks the cycle after the read ack, when the held load finally retires.
    assign miss         = load_req & ~hit & ~rd_done;
    assign miss_pending = miss & ~rd_ack;

    always_comb begin
        stall_raw = 1'b0;
        if (cpu_wen) begin
            stall_raw = fifo_full & ~wr_ack;
        end else if (load_req) begin
            stall_raw = miss;
        end
    end

    assign cpu_stall    = rst & stall_raw;
    assign push         = cpu_wen & ~stall_raw;
    assign nonempty_nxt = push | (~fifo_empty & ~(wr_ack & fifo_single));

    // A load miss jumps ahead of buffered writes: missing the buffer proves no overlap.
    always_comb begin
        next_busy = cpu_pkg::IDLE;
        if (miss_pending) begin
            next_busy = cpu_pkg::RD_BUSY;
        end else if (nonempty_nxt) begin
            next_busy = cpu_pkg::WR_BUSY;
        end

        state_nxt = state;
        case (state)
            cpu_pkg::WR_BUSY,
            cpu_pkg::RD_BUSY: if (mem_ack) state_nxt = next_busy;
            default:          state_nxt = next_busy;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= cpu_pkg::IDLE;
            rd_addr_q <= '0;
            rd_done   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state   <= state_nxt;
            rd_done <= rd_ack;
            if ((state_nxt == cpu_pkg::RD_BUSY) && (state != cpu_pkg::RD_BUSY)) begin
                rd_addr_q <= cpu_addr;
            end
            if (rd_ack) begin
                cpu_rdata <= mem_rdata;
            end else if (load_req && hit && !rd_done) begin
                cpu_rdata <= hit_data;
            end
        end
    end

    // Backing-memory outputs decode straight from the state, so reset idles them at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            cpu_pkg::WR_BUSY: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            cpu_pkg::RD_BUSY: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stores/loads push expected
// memory transfers and load data; a negedge monitor pops and compares them.
module tb_dmem_responder;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    typedef struct packed {
        logic        we;
        wbuf_entry_t ent;
    } xfer_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wen;
    logic          cpu_ren;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    dmem_responder #(
        .DEPTH (DEPTH),
        .DSIZE (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wen   (cpu_wen),
        .cpu_ren   (cpu_ren),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing-memory responder: acks ack_delay cycles into each request, or on demand.
    logic          ack_en     = 1'b0;
    int            ack_delay  = 1;
    logic          manual_ack = 1'b0;
    logic [DW-1:0] rd_return  = '0;
    int            wait_cnt   = 0;
    logic          auto_ack;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        #2;
        auto_ack = 1'b0;
        if (ack_en && rst && mem_req) begin
            if (wait_cnt >= ack_delay) begin
                auto_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        mem_ack   = auto_ack | manual_ack;
        mem_rdata = mem_ack ? rd_return : '0;
    end

    // Scoreboard queues and monitor.
    xfer_t         mem_q[$];
    logic [DW-1:0] load_q[$];
    xfer_t         mon_x;
    logic          load_fire_q = 1'b0;
    int            rd_ack_cyc  = -100;

    always @(negedge clk) begin
        if (load_fire_q) begin
            check("load_expected", load_q.size() != 0, 1);
            if (load_q.size() != 0) check("load_rdata", cpu_rdata, load_q.pop_front());
        end
        load_fire_q = rst && cpu_ren && !cpu_wen && !cpu_stall;
        if (rst && mem_req && mem_ack) begin
            check("xfer_expected", mem_q.size() != 0, 1);
            if (mem_q.size() != 0) begin
                mon_x = mem_q.pop_front();
                check("xfer_we", mem_we, mon_x.we);
                check("xfer_addr", mem_addr, mon_x.ent.addr);
                if (mon_x.we) check("xfer_wdata", mem_wdata, mon_x.ent.data);
                else          rd_ack_cyc = cyc;
            end
        end
    end

    task automatic exp_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
        xfer_t x;
        x.we = 1'b1; x.ent.addr = a; x.ent.data = d;
        mem_q.push_back(x);
    endtask

    task automatic exp_rd(input logic [DW-1:0] a);
        xfer_t x;
        x.we = 1'b0; x.ent.addr = a; x.ent.data = '0;
        mem_q.push_back(x);
    endtask

    // Drivers start and end #1 after a rising edge.
    task automatic do_store(input logic [DW-1:0] a, input logic [DW-1:0] d,
                            input logic also_ren, output int stalls);
        int guard = 0;
        cpu_wen = 1'b1; cpu_ren = also_ren; cpu_addr = a; cpu_wdata = d;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && guard < 100) begin
            stalls++; guard++;
            @(negedge clk);
        end
        check("store_accept_in_bound", guard < 100, 1);
        @(posedge clk); #1;
        cpu_ren = 1'b0;
    endtask

    int accept_cyc = 0;

    task automatic do_load(input logic [DW-1:0] a, input logic [DW-1:0] exp, output int stalls);
        int guard = 0;
        load_q.push_back(exp);
        cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_addr = a;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && guard < 100) begin
            stalls++; guard++;
            @(negedge clk);
        end
        check("load_accept_in_bound", guard < 100, 1);
        accept_cyc = cyc;
        @(posedge clk); #1;
        cpu_ren = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_wen = 1'b0; cpu_ren = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        cpu_wen = 1'b0; cpu_ren = 1'b0;
        @(negedge clk);
        while ((mem_q.size() != 0 || mem_req) && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        check({name, "_queue_drained"}, mem_q.size(), 0);
        check({name, "_req_idle"}, mem_req, 0);
        @(posedge clk); #1;
        idle(4);
        check({name, "_stays_idle"}, mem_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0, s1, s2, req_seen;

    initial begin
        rst = 1'b0;
        cpu_wen = 1'b1; cpu_ren = 1'b1; cpu_addr = 16'h0099; cpu_wdata = 16'h5555;

        // Reset state, with requests present to show stall is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", cpu_stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        @(posedge clk); #1;
        cpu_wen = 1'b0; cpu_ren = 1'b0;
        rst = 1'b1;
        idle(2);

        // Two stores drain in order; the second also raises cpu_ren and must act as a store only.
        ack_en = 1'b1; ack_delay = 1;
        exp_wr(16'h0010, 16'hAAAA);
        exp_wr(16'h0011, 16'hBBBB);
        do_store(16'h0010, 16'hAAAA, 1'b0, s0);
        do_store(16'h0011, 16'hBBBB, 1'b1, s1);
        check("t1_no_stall", s0 + s1, 0);
        drain("t1");

        // Store then immediate load forwards from the buffer; acks withheld.
        ack_en = 1'b0;
        exp_wr(16'h0020, 16'h1234);
        do_store(16'h0020, 16'h1234, 1'b0, s0);
        do_load(16'h0020, 16'h1234, s1);
        check("t2_no_stall", s0 + s1, 0);

        // Two more stores to the same address: newest entry wins.
        exp_wr(16'h0020, 16'h1111);
        exp_wr(16'h0020, 16'h2222);
        do_store(16'h0020, 16'h1111, 1'b0, s0);
        do_store(16'h0020, 16'h2222, 1'b0, s1);
        do_load(16'h0020, 16'h2222, s2);
        check("t3_no_stall", s0 + s1 + s2, 0);
        ack_en = 1'b1;
        drain("t3");

        // Fill the buffer; the fifth store stalls until the head is acked.
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) exp_wr(16'h0030 + 16'(i), 16'h3000 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            do_store(16'h0030 + 16'(i), 16'h3000 + 16'(i), 1'b0, s0);
            check("t4_fill_no_stall", s0, 0);
        end
        cpu_wen = 1'b1; cpu_addr = 16'h0034; cpu_wdata = 16'h3004;
        @(negedge clk);
        check("t4_full_stalls", cpu_stall, 1);
        @(posedge clk); #1;
        manual_ack = 1'b1;
        @(negedge clk);
        check("t4_pop_accepts_store", cpu_stall, 0);
        @(posedge clk); #1;
        manual_ack = 1'b0;
        cpu_wen = 1'b0;
        ack_en = 1'b1;
        drain("t4");

        // Load miss behind two buffered writes is served before the second write.
        ack_en = 1'b0; ack_delay = 1;
        exp_wr(16'h0040, 16'h4000);
        exp_rd(16'h0050);
        exp_wr(16'h0041, 16'h4100);
        do_store(16'h0040, 16'h4000, 1'b0, s0);
        do_store(16'h0041, 16'h4100, 1'b0, s1);
        rd_return = 16'hBEEF;
        ack_en = 1'b1;
        do_load(16'h0050, 16'hBEEF, s2);
        check("t5_miss_stalled", s2 > 0, 1);
        check("t5_stall_drops_after_ack", accept_cyc - rd_ack_cyc, 1);
        drain("t5");

        // Reset in mid-write abandons the transfer and the buffered writes.
        ack_en = 1'b0;
        do_store(16'h0060, 16'h6000, 1'b0, s0);
        do_store(16'h0061, 16'h6100, 1'b0, s0);
        do_store(16'h0062, 16'h6200, 1'b0, s0);
        cpu_wen = 1'b0;
        @(negedge clk);
        check("t6_busy_before_reset", mem_req, 1);
        @(posedge clk); #1;
        cpu_wen = 1'b1; cpu_addr = 16'h0063;
        rst = 1'b0;
        #1;
        check("t6_req_drops_async", mem_req, 0);
        check("t6_stall_low_in_reset", cpu_stall, 0);
        @(posedge clk); #1;
        cpu_wen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        manual_ack = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        check("t6_no_transfer_after_reset", req_seen, 0);
        @(posedge clk); #1;

        // Discarded writes must not forward: a load of 0x0060 now misses.
        ack_en = 1'b1;
        rd_return = 16'h5A5A;
        exp_wr(16'h0070, 16'h7777);
        exp_rd(16'h0060);
        do_store(16'h0070, 16'h7777, 1'b0, s0);
        do_load(16'h0060, 16'h5A5A, s1);
        check("t6_discarded_load_misses", s1 > 0, 1);
        drain("t6");

        check("load_queue_empty", load_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
